// File: rtl/vx_core_rsp_batcher.sv
// vx_core_rsp_batcher: merges cache bank responses that share a tag ID into
// one multi-lane core response. The leader bank is chosen round-robin. The
// assembled batch goes into a 2-entry skid buffer in front of the core.
// Optional feature macro: VX_RSP_BATCHER_PERF_EN (stall/batch counters).
module vx_core_rsp_batcher #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_BANKS   = 4,
  parameter int NUM_PORTS   = 2,
  parameter int WORD_SIZE   = 4,
  parameter int TAG_WIDTH   = 16,
  parameter int TAG_ID_BITS = 4,
  parameter int PERF_W      = 32,
  localparam int TID_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int WORD_W = 8 * WORD_SIZE
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_BANKS-1:0]                    per_bank_rsp_valid,
  input  logic [NUM_BANKS*NUM_PORTS-1:0]          per_bank_rsp_pmask,
  input  logic [NUM_BANKS*NUM_PORTS*WORD_W-1:0]   per_bank_rsp_data,
  input  logic [NUM_BANKS*NUM_PORTS*TID_W-1:0]    per_bank_rsp_tid,
  input  logic [NUM_BANKS*TAG_WIDTH-1:0]          per_bank_rsp_tag,
  output logic [NUM_BANKS-1:0]                    per_bank_rsp_ready,
  output logic                                    core_rsp_valid,
  output logic [NUM_REQS-1:0]                     core_rsp_tmask,
  output logic [TAG_WIDTH-1:0]                    core_rsp_tag,
  output logic [NUM_REQS*WORD_W-1:0]              core_rsp_data,
  input  logic                                    core_rsp_ready,
  output logic [PERF_W-1:0]                       perf_stall_cycles,
  output logic [PERF_W-1:0]                       perf_batches
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [BANK_W-1:0]          rr_ptr;
  int unsigned                rr_i;
  int unsigned                lead_idx;
  logic                       have_leader;
  logic                       in_order;
  logic [TAG_WIDTH-1:0]       lead_tag;
  logic [NUM_BANKS-1:0]       match, collided, selected;
  logic [NUM_REQS-1:0]        claimed;
  logic [NUM_REQS-1:0]        bat_tmask;
  logic [NUM_REQS*WORD_W-1:0] bat_data;
  logic                       push, pop;

  logic [NUM_REQS-1:0]        buf_tmask [2];
  logic [TAG_WIDTH-1:0]       buf_tag   [2];
  logic [NUM_REQS*WORD_W-1:0] buf_data  [2];
  logic                       rd_ptr, wr_ptr;
  logic [1:0]                 count;

  function automatic logic lane_hit(input logic [TID_W-1:0] tid, input int unsigned lane);
    if (NUM_REQS == 1) return (lane == 0);
    return (tid == TID_W'(lane));
  endfunction

  // Leader pick, match set, collision scan and batch assembly.
  // The cyclic scans start at rr_ptr rather than at the leader: every bank
  // between the two is invalid, so the visiting order of matched banks is the same.
  always_comb begin
    rr_i        = 32'(rr_ptr);
    have_leader = 1'b0;
    lead_idx    = 0;
    lead_tag    = '0;
    in_order    = 1'b0;
    match       = '0;
    collided    = '0;
    selected    = '0;
    claimed     = '0;
    bat_tmask   = '0;
    bat_data    = '0;

    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        in_order = (pass == 0) ? (i >= rr_i) : (i < rr_i);
        if (in_order && per_bank_rsp_valid[i] && !have_leader) begin
          have_leader = 1'b1;
          lead_idx    = i;
          lead_tag    = per_bank_rsp_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
      end
    end

    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      match[i] = have_leader && per_bank_rsp_valid[i] &&
                 (per_bank_rsp_tag[i*TAG_WIDTH +: TAG_ID_BITS] == lead_tag[TAG_ID_BITS-1:0]);
    end

    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        in_order = (pass == 0) ? (i >= rr_i) : (i < rr_i);
        if (in_order && match[i]) begin
          for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned l = 0; l < NUM_REQS; l++) begin
              if (per_bank_rsp_pmask[i*NUM_PORTS+p] &&
                  lane_hit(per_bank_rsp_tid[(i*NUM_PORTS+p)*TID_W +: TID_W], l)) begin
                if (claimed[l]) collided[i] = 1'b1;
                else            claimed[l]  = 1'b1;
              end
            end
          end
        end
      end
    end

    // The leader always goes out; a duplicate lane inside it keeps the first port.
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      selected[i] = match[i] && (!collided[i] || (i == lead_idx));
    end

    // Rebuild from selected banks only so that held banks leave no trace.
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        in_order = (pass == 0) ? (i >= rr_i) : (i < rr_i);
        if (in_order && selected[i]) begin
          for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned l = 0; l < NUM_REQS; l++) begin
              if (per_bank_rsp_pmask[i*NUM_PORTS+p] && !bat_tmask[l] &&
                  lane_hit(per_bank_rsp_tid[(i*NUM_PORTS+p)*TID_W +: TID_W], l)) begin
                bat_tmask[l] = 1'b1;
                bat_data[l*WORD_W +: WORD_W] =
                  per_bank_rsp_data[(i*NUM_PORTS+p)*WORD_W +: WORD_W];
              end
            end
          end
        end
      end
    end
  end

  assign push               = have_leader && (count != 2'd2) && !reset;
  assign pop                = (count != 2'd0) && core_rsp_ready;
  assign per_bank_rsp_ready = push ? selected : '0;

  assign core_rsp_valid = (count != 2'd0);
  assign core_rsp_tmask = buf_tmask[rd_ptr];
  assign core_rsp_tag   = buf_tag[rd_ptr];
  assign core_rsp_data  = buf_data[rd_ptr];

  // Skid buffer storage, occupancy and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      for (int unsigned e = 0; e < 2; e++) begin
        buf_tmask[e] <= '0;
        buf_tag[e]   <= '0;
        buf_data[e]  <= '0;
      end
    end else begin
      if (push) begin
        buf_tmask[wr_ptr] <= bat_tmask;
        buf_tag[wr_ptr]   <= lead_tag;
        buf_data[wr_ptr]  <= bat_data;
        wr_ptr            <= ~wr_ptr;
        rr_ptr            <= BANK_W'((lead_idx + 1) % NUM_BANKS);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef VX_RSP_BATCHER_PERF_EN
  logic [PERF_W-1:0] stall_q, batch_q;

  // Saturating stall and accepted-batch counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      batch_q <= '0;
    end else begin
      if (core_rsp_valid && !core_rsp_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (push && (batch_q != '1)) batch_q <= batch_q + 1'b1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_batches      = batch_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_batches      = '0;
`endif

endmodule

// File: tb/tb_vx_core_rsp_batcher.sv
// Directed bench for vx_core_rsp_batcher with hand-computed expectations.
module tb_vx_core_rsp_batcher;
  localparam int NR = 4, NB = 4, NP = 2, WS = 4, TW = 16, TIB = 4, PW = 32;
  localparam int WW = 32, TIDW = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NB-1:0]        per_bank_rsp_valid;
  logic [NB*NP-1:0]     per_bank_rsp_pmask;
  logic [NB*NP*WW-1:0]  per_bank_rsp_data;
  logic [NB*NP*TIDW-1:0] per_bank_rsp_tid;
  logic [NB*TW-1:0]     per_bank_rsp_tag;
  logic [NB-1:0]        per_bank_rsp_ready;
  logic                 core_rsp_valid;
  logic [NR-1:0]        core_rsp_tmask;
  logic [TW-1:0]        core_rsp_tag;
  logic [NR*WW-1:0]     core_rsp_data;
  logic                 core_rsp_ready;
  logic [PW-1:0]        perf_stall_cycles;
  logic [PW-1:0]        perf_batches;

  int n_checks = 0;
  int n_fails  = 0;

  vx_core_rsp_batcher #(
    .NUM_REQS(NR), .NUM_BANKS(NB), .NUM_PORTS(NP), .WORD_SIZE(WS),
    .TAG_WIDTH(TW), .TAG_ID_BITS(TIB), .PERF_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .per_bank_rsp_valid(per_bank_rsp_valid), .per_bank_rsp_pmask(per_bank_rsp_pmask),
    .per_bank_rsp_data(per_bank_rsp_data), .per_bank_rsp_tid(per_bank_rsp_tid),
    .per_bank_rsp_tag(per_bank_rsp_tag), .per_bank_rsp_ready(per_bank_rsp_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_tmask(core_rsp_tmask),
    .core_rsp_tag(core_rsp_tag), .core_rsp_data(core_rsp_data),
    .core_rsp_ready(core_rsp_ready),
    .perf_stall_cycles(perf_stall_cycles), .perf_batches(perf_batches)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_banks();
    per_bank_rsp_valid = '0;
    per_bank_rsp_pmask = '0;
    per_bank_rsp_data  = '0;
    per_bank_rsp_tid   = '0;
    per_bank_rsp_tag   = '0;
  endtask

  task automatic set_bank(input int b, input logic [1:0] pm, input logic [1:0] t0,
                          input logic [1:0] t1, input logic [15:0] tg,
                          input logic [31:0] d0, input logic [31:0] d1);
    per_bank_rsp_valid[b]            = 1'b1;
    per_bank_rsp_pmask[b*2 +: 2]     = pm;
    per_bank_rsp_tid[b*4 +: 2]       = t0;
    per_bank_rsp_tid[b*4+2 +: 2]     = t1;
    per_bank_rsp_tag[b*16 +: 16]     = tg;
    per_bank_rsp_data[b*64 +: 32]    = d0;
    per_bank_rsp_data[b*64+32 +: 32] = d1;
  endtask

  initial begin
    logic [127:0] ed;
    logic [31:0]  exp_stall, exp_batches;
    int           b;

    reset = 1'b1;
    core_rsp_ready = 1'b1;
    clear_banks();
    tick();
    tick();
    check("rst_valid", core_rsp_valid, 0);
    check("rst_tmask", core_rsp_tmask, 0);
    check("rst_tag",   core_rsp_tag, 0);
    check("rst_data",  core_rsp_data, 0);
    check("rst_ready", per_bank_rsp_ready, 0);
    check("rst_stall", perf_stall_cycles, 0);
    check("rst_batches", perf_batches, 0);
    reset = 1'b0;

    // Single bank
    set_bank(2, 2'b01, 2'd3, 2'd0, 16'h0015, 32'hA5A5A5A5, 32'h0);
    #1 check("single_ready", per_bank_rsp_ready, 4'b0100);
    tick();
    clear_banks();
    check("single_valid", core_rsp_valid, 1);
    check("single_tmask", core_rsp_tmask, 4'b1000);
    check("single_tag",   core_rsp_tag, 16'h0015);
    ed = {32'hA5A5A5A5, 96'h0};
    check("single_data",  core_rsp_data, ed);
    #1 check("single_ready_once", per_bank_rsp_ready, 0);
    tick();
    check("single_drained", core_rsp_valid, 0);

    // Merge: rr_ptr=3, leader bank0
    set_bank(0, 2'b11, 2'd0, 2'd1, 16'h0105, 32'h11, 32'h22);
    set_bank(1, 2'b11, 2'd2, 2'd3, 16'h0205, 32'h33, 32'h44);
    #1 check("merge_ready", per_bank_rsp_ready, 4'b0011);
    tick();
    clear_banks();
    check("merge_valid", core_rsp_valid, 1);
    check("merge_tmask", core_rsp_tmask, 4'b1111);
    check("merge_tag",   core_rsp_tag, 16'h0105);
    ed = {32'h44, 32'h33, 32'h22, 32'h11};
    check("merge_data",  core_rsp_data, ed);

    // Filler from rr_ptr=1: only bank3 valid -> leader 3, rr_ptr wraps to 0
    set_bank(3, 2'b01, 2'd1, 2'd0, 16'h0009, 32'h99, 32'h0);
    #1 check("fill_ready", per_bank_rsp_ready, 4'b1000);
    tick();
    clear_banks();
    check("fill_tmask", core_rsp_tmask, 4'b0010);
    check("fill_tag",   core_rsp_tag, 16'h0009);
    ed = {64'h0, 32'h99, 32'h0};
    check("fill_data",  core_rsp_data, ed);

    // Collision on lane 2, rr_ptr=0
    set_bank(0, 2'b01, 2'd2, 2'd0, 16'h0007, 32'hAA, 32'h0);
    set_bank(1, 2'b11, 2'd2, 2'd0, 16'h0017, 32'hBB, 32'hCC);
    #1 check("coll_ready1", per_bank_rsp_ready, 4'b0001);
    tick();
    per_bank_rsp_valid[0] = 1'b0;
    check("coll_tmask1", core_rsp_tmask, 4'b0100);
    check("coll_tag1",   core_rsp_tag, 16'h0007);
    ed = {32'h0, 32'hAA, 64'h0};
    check("coll_data1",  core_rsp_data, ed);
    #1 check("coll_ready2", per_bank_rsp_ready, 4'b0010);
    tick();
    clear_banks();
    check("coll_valid2", core_rsp_valid, 1);
    check("coll_tmask2", core_rsp_tmask, 4'b0101);
    check("coll_tag2",   core_rsp_tag, 16'h0017);
    ed = {32'h0, 32'hBB, 32'h0, 32'hCC};
    check("coll_data2",  core_rsp_data, ed);

    // Fairness: rr_ptr=2, all banks valid with distinct tag IDs
    for (int i = 0; i < 4; i++)
      set_bank(i, 2'b01, 2'(i), 2'd0, 16'h00A0 | 16'(i), 32'(i + 1), 32'h0);
    for (int k = 0; k < 5; k++) begin
      b = (2 + k) % 4;
      #1 check($sformatf("fair_ready%0d", k), per_bank_rsp_ready, 4'b0001 << b);
      tick();
      check($sformatf("fair_valid%0d", k), core_rsp_valid, 1);
      check($sformatf("fair_tag%0d", k), core_rsp_tag, 16'h00A0 | 16'(b));
      check($sformatf("fair_tmask%0d", k), core_rsp_tmask, 4'b0001 << b);
      ed = 128'(b + 1) << (32 * b);
      check($sformatf("fair_data%0d", k), core_rsp_data, ed);
    end
    clear_banks();
    tick();
    check("fair_drained", core_rsp_valid, 0);

    // Backpressure: rr_ptr=3, core not ready for 5 cycles
    core_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      set_bank(i, 2'b01, 2'(i), 2'd0, 16'h00A0 | 16'(i), 32'(i + 1), 32'h0);
    #1 check("bp_ready0", per_bank_rsp_ready, 4'b1000);
    tick();
    check("bp_valid1", core_rsp_valid, 1);
    check("bp_tag1",   core_rsp_tag, 16'h00A3);
    #1 check("bp_ready1", per_bank_rsp_ready, 4'b0001);
    ed = {32'h4, 96'h0};
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("bp_valid%0d", k), core_rsp_valid, 1);
      check($sformatf("bp_tag%0d", k),   core_rsp_tag, 16'h00A3);
      check($sformatf("bp_tmask%0d", k), core_rsp_tmask, 4'b1000);
      check($sformatf("bp_data%0d", k),  core_rsp_data, ed);
      #1 check($sformatf("bp_full_ready%0d", k), per_bank_rsp_ready, 0);
    end
`ifdef VX_RSP_BATCHER_PERF_EN
    exp_stall = 32'd4;
    exp_batches = 32'd12;
`else
    exp_stall = 32'd0;
    exp_batches = 32'd0;
`endif
    check("bp_perf_stall",   perf_stall_cycles, exp_stall);
    check("bp_perf_batches", perf_batches, exp_batches);

    // Reset with two batches buffered
    reset = 1'b1;
    #1 check("rst2_ready_in_reset", per_bank_rsp_ready, 0);
    tick();
    check("rst2_valid", core_rsp_valid, 0);
    check("rst2_tmask", core_rsp_tmask, 0);
    check("rst2_tag",   core_rsp_tag, 0);
    check("rst2_data",  core_rsp_data, 0);
    check("rst2_stall", perf_stall_cycles, 0);
    check("rst2_batches", perf_batches, 0);
    reset = 1'b0;
    core_rsp_ready = 1'b1;
    #1 check("rst2_rr_leader0", per_bank_rsp_ready, 4'b0001);
    tick();
    clear_banks();
    check("rst2_out_valid", core_rsp_valid, 1);
    check("rst2_out_tag",   core_rsp_tag, 16'h00A0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
